// File: rtl/ape_mem_arbiter.sv
// ape_mem_arbiter: round-robin arbiter that shares one APE core memory port
// between NUM_REQ requesters and routes in-order read responses back.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i/add_i/opc_i   per-requester request, address (packed, req 0 in LSBs), opcode
//   gnt_o               per-requester grant (one-hot or zero, same cycle as m_gnt_i)
//   r_valid_o           per-requester response valid (one-hot or zero)
//   r_rdata_o           response data, broadcast to all requesters
//   m_req_o/m_add_o/m_opc_o/m_gnt_i           memory request channel
//   m_r_valid_i/m_r_rdata_i                   memory response channel
//   busy_o              at least one transaction in flight
//   err_o               sticky: response arrived with nothing outstanding
module ape_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] add_i,
    input  logic [NUM_REQ-1:0]        opc_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        r_valid_o,
    output logic [DATA_W-1:0]         r_rdata_o,
    output logic                      m_req_o,
    output logic [ADDR_W-1:0]         m_add_o,
    output logic                      m_opc_o,
    input  logic                      m_gnt_i,
    input  logic                      m_r_valid_i,
    input  logic [DATA_W-1:0]         m_r_rdata_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // ST_LOCKED: memory saw a request but has not granted it yet, so the
    // same requester must stay on the bus until it is accepted.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e        state_q, state_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   fifo_q [MAX_OUTST];
    logic [IDX_W-1:0]   fifo_d [MAX_OUTST];

    logic               en;
    logic               any_req;
    logic [IDX_W-1:0]   scan_idx;
    logic               have_req;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   sel;
    logic               push;
    logic               pop;
    logic               stray;
    logic [IDX_W-1:0]   head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Issue is gated on the registered count only; a pop in this cycle
    // does not free a slot until the next one.
    assign en = (cnt_q < CNT_W'(MAX_OUTST));

    // Round-robin scan starting at rr_q, wrapping modulo NUM_REQ.
    always_comb begin : scan
        logic [IDX_W:0] pos;
        pos      = '0;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_q} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
            if (!any_req && req_i[pos[IDX_W-1:0]]) begin
                any_req  = 1'b1;
                scan_idx = pos[IDX_W-1:0];
            end
        end
    end

    // A locked request is never withdrawn; requester holds req_i meanwhile.
    assign have_req = (state_q == ST_LOCKED) || any_req;
    assign win      = (state_q == ST_LOCKED) ? lock_idx_q : scan_idx;
    assign sel      = have_req ? win : '0;

    assign m_req_o  = en && have_req;
    assign m_add_o  = add_i[sel*ADDR_W +: ADDR_W];
    assign m_opc_o  = opc_i[sel];

    assign push     = m_req_o && m_gnt_i;
    assign pop      = m_r_valid_i && (cnt_q != '0);
    assign stray    = m_r_valid_i && (cnt_q == '0);
    assign head     = fifo_q[rd_ptr_q];

    assign gnt_o     = push ? (NUM_REQ'(1) << win) : '0;
    assign r_valid_o = pop ? (NUM_REQ'(1) << head) : '0;
    assign r_rdata_o = m_r_rdata_i;
    assign busy_o    = (cnt_q != '0);
    assign err_o     = err_q;

    always_comb begin : next_state
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q | stray;
        for (int i = 0; i < MAX_OUTST; i++) begin
            fifo_d[i] = fifo_q[i];
        end

        if (push) begin
            state_d          = ST_OPEN;
            rr_d             = idx_inc(win);
            fifo_d[wr_ptr_q] = win;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else if (m_req_o) begin
            // Request presented but not granted: pin it.
            state_d    = ST_LOCKED;
            lock_idx_d = win;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_OPEN;
            lock_idx_q <= '0;
            rr_q       <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule
